// File: rtl/disp_scan_ctrl_pkg.sv
// Shared display package for the seven-segment scan path.
// Holds the digit geometry, the all-off anode pattern and helpers that
// pack the raw data/point inputs into digit words and decide leading-zero
// blanking.
package disp_scan_ctrl_pkg;

    localparam int SCAN_DIGITS = 4;
    localparam int DIGIT_W     = 5;
    localparam int NIB_W       = 4;

    localparam logic [SCAN_DIGITS-1:0] AN_OFF = 4'b1111;

    // Digit k lives in element k as {point, nibble}.
    typedef logic [SCAN_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    function automatic digits_t pack_digits(
        input logic [SCAN_DIGITS*NIB_W-1:0] nibbles,
        input logic [SCAN_DIGITS-1:0]       points
    );
        digits_t w;
        for (int k = 0; k < SCAN_DIGITS; k++) begin
            w[k] = {points[k], nibbles[k*NIB_W +: NIB_W]};
        end
        return w;
    endfunction

    // A digit is a leading zero when it and every more significant digit
    // carry neither a nonzero nibble nor a decimal point. Digit 0 always
    // shows so a value of zero still displays "0".
    function automatic logic lz_blanked(
        input digits_t    w,
        input logic [1:0] k,
        input logic       blank_lz
    );
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < SCAN_DIGITS; j++) begin
            if (j >= int'(k) && w[j] != '0) begin
                all_zero = 1'b0;
            end
        end
        return blank_lz && (k != 2'd0) && all_zero;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - count enable; the counter freezes while low
//   tick - one-cycle strobe while enabled with the counter at all-ones
module scan_prescaler #(
    parameter int DIV_W = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Free-running up-counter that wraps naturally from all-ones to zero.
    always_comb begin
        cnt_d = en ? cnt_q + DIV_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & (&cnt_q);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for the 4-digit seven-segment display.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   en              - scan enable; low freezes the scan and blanks the anodes
//   load            - strobe capturing data_in/point_in
//   data_in         - four hex nibbles, nibble k for digit k
//   point_in        - decimal point per digit
//   blank_lz        - enable leading-zero blanking
//   scan            - digit select for the downstream 4-to-1 multiplexer
//   d0..d3          - digit words {point, nibble} for multiplexer inputs 0..3
//   an              - active-low anode enables
//   frame           - one-cycle pulse after each frame boundary
//   pending         - loaded data is waiting for a frame boundary
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int DIV_W = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [15:0]              data_in,
    input  logic [3:0]               point_in,
    input  logic                     blank_lz,
    output logic [1:0]               scan,
    output logic [DIGIT_W-1:0]       d0,
    output logic [DIGIT_W-1:0]       d1,
    output logic [DIGIT_W-1:0]       d2,
    output logic [DIGIT_W-1:0]       d3,
    output logic [SCAN_DIGITS-1:0]   an,
    output logic                     frame,
    output logic                     pending
);

    logic                   tick;
    logic                   boundary;
    logic                   apply;
    logic [1:0]             scan_q;
    logic [1:0]             scan_d;
    digits_t                load_word;
    digits_t                shadow_q;
    digits_t                shadow_d;
    digits_t                pend_q;
    digits_t                pend_d;
    logic                   pending_q;
    logic                   pending_d;
    logic                   frame_q;
    logic [SCAN_DIGITS-1:0] an_q;
    logic [SCAN_DIGITS-1:0] an_d;
    logic [SCAN_DIGITS-1:0] one_hot;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Shadow update: while scanning, new data only lands at the frame
    // boundary; while stopped there is no frame to protect, so any load or
    // leftover pending data is applied on the very next edge. A load in the
    // applying cycle bypasses the pending register entirely.
    always_comb begin
        load_word = pack_digits(data_in, point_in);
        boundary  = tick && (scan_q == 2'd3);
        apply     = !en || boundary;
        scan_d    = tick ? scan_q + 2'd1 : scan_q;
        pend_d    = load ? load_word : pend_q;
        shadow_d  = shadow_q;
        pending_d = pending_q | load;
        if (apply) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_d = load_word;
            end else if (pending_q) begin
                shadow_d = pend_q;
            end
        end
    end

    // The anode register is computed from the next scan and next shadow so
    // it never shows a stale blank decision next to a freshly loaded digit.
    always_comb begin
        one_hot = SCAN_DIGITS'(1) << scan_d;
        if (!en || lz_blanked(shadow_d, scan_d, blank_lz)) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~one_hot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q    <= 2'd0;
            shadow_q  <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            an_q      <= AN_OFF;
        end else begin
            scan_q    <= scan_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            frame_q   <= boundary;
            an_q      <= an_d;
        end
    end

    assign scan    = scan_q;
    assign d0      = shadow_q[0];
    assign d1      = shadow_q[1];
    assign d2      = shadow_q[2];
    assign d3      = shadow_q[3];
    assign an      = an_q;
    assign frame   = frame_q;
    assign pending = pending_q;

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the 4-digit seven-segment display path. Holds the displayed value in a frame-stable shadow register, produces the 2-bit scan select and the four 5-bit digit words that drive the downstream 5-bit 4-to-1 digit multiplexer (select and I0..I3), and generates the active-low anode enables. New data is accepted at any time and applied only at a frame boundary, so a digit never changes mid-frame.

## Interface
- DIV_W, 17: prescaler width; one scan step every 2^DIV_W clocks (about 763 Hz per digit at 100 MHz).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low holds the scan position and blanks all anodes.
- load  in  1  single-cycle strobe that captures data_in/point_in.
- data_in  in  16  four hex nibbles; nibble k = data_in[4k+3:4k] goes to digit k.
- point_in  in  4  decimal point per digit; bit k goes to digit k.
- blank_lz  in  1  blank leading zeros when high.
- scan  out  2  digit select to the downstream multiplexer.
- d0, d1, d2, d3  out  5 each  digit word {point, nibble} for multiplexer inputs 0..3.
- an  out  4  anode enables, active-low; one-hot low or all high.
- frame  out  1  one-cycle pulse on each frame boundary.
- pending  out  1  high while loaded data waits for a boundary.

## Operation
- Prescaler: DIV_W-bit up-counter that advances only while en=1. tick = en and prescaler all-ones. It wraps to 0 after all-ones.
- Scan: on tick, scan <= scan+1, wrapping 3->0. Boundary = tick while scan==3.
- Load path: load=1 writes pending_data and sets pending.
- At a boundary, shadow <= pending_data and pending clears. If load and the boundary occur in the same cycle, shadow takes the data being loaded in that cycle and pending stays 0.
- If en=0, load writes the shadow directly on that edge and pending stays 0. A pending that is already set when en falls is applied on the next edge.
- d0..d3 are always driven from the shadow, including blanked digits.
- Leading-zero blank: digit k (k=1..3) is blanked when blank_lz=1 and, for every j from k to 3, nibble j = 0 and point j = 0. Digit 0 is never blanked. Blanking is evaluated on the shadow.
- Anode: an = 4'b1111 if en=0 or the digit is blanked; otherwise an = ~(4'b0001 << scan).

## Timing
- Reset values: prescaler 0, scan 0, an 4'b1111, d0..d3 0, shadow 0, pending_data 0, pending 0, frame 0.
- scan and an are registered and change on the same edge. an always matches the registered scan, with the blank state computed from the next shadow value.
- frame is registered: it is high for the one cycle after the boundary edge, the same cycle in which scan=0 and the new shadow are first visible.
- Load-to-display latency: at most 4·2^DIV_W clocks plus 1 when en=1; 1 clock when en=0.
- Back-to-back loads before a boundary: the last one wins.
- When en goes low, the prescaler and scan freeze. When en goes high again, scanning resumes from the held values.
- Asynchronous rst during a frame: all state returns to reset values immediately, and the pending load is discarded.

## Structure
- Shared display package holds SCAN_DIGITS=4, DIGIT_W=5, NIB_W=4 and AN_OFF=4'b1111.
- One natural sub-module: scan_prescaler. It has parameter DIV_W and ports clk, rst, en, tick.
- Blank decode and anode generation stay in the top level as combinational logic feeding the registers.

## Test plan
- Reset with DIV_W=2, rst held, then released with en=1 -> an=1111 and scan=0 during reset. Afterwards scan steps 0,1,2,3,0 every 4 clocks and an follows 1110,1101,1011,0111.
- load data_in=16'h1234, point_in=4'b0100 mid-frame -> pending=1 and d0..d3 unchanged until the boundary. On the next frame cycle: d0=5'h04, d1=5'h03, d2=5'h12, d3=5'h01, frame=1, pending=0.
- load at the exact boundary cycle -> the new value appears at scan=0 with pending never asserted. Two loads 16'hAAAA then 16'h5555 within one frame -> only 16'h5555 is displayed.
- blank_lz=1 with data 16'h0050 and points 0 -> an stays 1111 during scan 3 and 2, and is active at scan 1 and 0. With point_in=4'b1000 -> no digit is blanked.
- en=0 with a load of 16'hBEEF -> shadow updates on the next clock, an=1111, and scan/prescaler hold. With en=1 again, scanning continues from the held scan value.
- rst pulsed while pending=1 at scan=2 -> every output returns to its reset value immediately. After release, d0..d3 stay 0 and the discarded load never appears.
